// File: rtl/output_drain_ctrl.sv
// output_drain_ctrl: serializes LANES-wide result vectors from the systolic
// array's output edge into single-word writes to the output buffer.
// Optional build macro OUTPUT_DRAIN_SATURATE_EN selects signed saturation to
// DATA_W; without it each lane is truncated to its low DATA_W bits.
`timescale 1ns/1ps
module output_drain_ctrl #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [CNT_W-1:0]         vec_count,
  input  logic                     res_valid,
  input  logic [LANES*ACC_W-1:0]   res_data,
  output logic                     res_ready,
  output logic [DATA_W-1:0]        st_data,
  output logic [ADDR_W-1:0]        st_addr,
  output logic                     st_en,
  output logic                     busy,
  output logic                     done,
  output logic                     wrapped
);

  localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         remaining_q, remaining_d;
  logic [LIDX_W-1:0]        lane_idx_q, lane_idx_d;
  logic [LANES*ACC_W-1:0]   hold_q, hold_d;
  logic                     wrapped_q, wrapped_d;
  logic                     res_ready_q, res_ready_d;
  logic [DATA_W-1:0]        st_data_q, st_data_d;
  logic [ADDR_W-1:0]        st_addr_q, st_addr_d;
  logic                     st_en_q, st_en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [ACC_W-1:0]         lane_sel;
  logic [DATA_W-1:0]        st_word;

  // Next-state and datapath: job setup, vector capture, per-lane write stepping.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    lane_idx_d  = lane_idx_q;
    hold_d      = hold_q;
    wrapped_d   = wrapped_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          wr_ptr_d    = base_addr;
          remaining_d = vec_count;
          wrapped_d   = 1'b0;
          state_d     = (vec_count != '0) ? ACCEPT : DONE;
        end
      end
      ACCEPT: begin
        if (res_valid) begin
          hold_d     = res_data;
          lane_idx_d = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (wr_ptr_q == '1) wrapped_d = 1'b1;
        if (lane_idx_q == LIDX_W'(LANES - 1)) begin
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? DONE : ACCEPT;
        end else begin
          lane_idx_d = lane_idx_q + LIDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register in step with it:
  // the flops show the word/address that belongs to the state being entered.
  always_comb begin
    lane_sel = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_idx_d == LIDX_W'(i)) lane_sel = hold_d[i*ACC_W +: ACC_W];
    end
  end

`ifdef OUTPUT_DRAIN_SATURATE_EN
  // Signed saturation: in range only if all bits above the DATA_W sign bit match it.
  always_comb begin
    logic [ACC_W-DATA_W:0] top;
    top = lane_sel[ACC_W-1:DATA_W-1];
    if (top == '0 || top == '1) begin
      st_word = lane_sel[DATA_W-1:0];
    end else if (lane_sel[ACC_W-1]) begin
      st_word = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      st_word = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic unused_lane_bits;
  // Plain truncation to the low DATA_W bits of the selected lane.
  always_comb begin
    st_word          = lane_sel[DATA_W-1:0];
    unused_lane_bits = ^lane_sel;
  end
`endif

  // Registered output values for the state being entered.
  always_comb begin
    st_en_d     = (state_d == WRITE);
    st_addr_d   = st_en_d ? wr_ptr_d : '0;
    st_data_d   = st_en_d ? st_word : '0;
    res_ready_d = (state_d == ACCEPT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      lane_idx_q  <= '0;
      hold_q      <= '0;
      wrapped_q   <= 1'b0;
      res_ready_q <= 1'b0;
      st_data_q   <= '0;
      st_addr_q   <= '0;
      st_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      lane_idx_q  <= lane_idx_d;
      hold_q      <= hold_d;
      wrapped_q   <= wrapped_d;
      res_ready_q <= res_ready_d;
      st_data_q   <= st_data_d;
      st_addr_q   <= st_addr_d;
      st_en_q     <= st_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign res_ready = res_ready_q;
  assign st_data   = st_data_q;
  assign st_addr   = st_addr_q;
  assign st_en     = st_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Scoreboard bench for output_drain_ctrl: stimulus pushes expected stores,
// a negedge monitor pops and compares whenever st_en is high.
`timescale 1ns/1ps
module tb_output_drain_ctrl;

  localparam int LANES = 4, ACC_W = 40, DATA_W = 32, ADDR_W = 4, CNT_W = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [ADDR_W-1:0]      base_addr = '0;
  logic [CNT_W-1:0]       vec_count = '0;
  logic                   res_valid = 1'b0;
  logic [LANES*ACC_W-1:0] res_data = '0;
  logic                   res_ready;
  logic [DATA_W-1:0]      st_data;
  logic [ADDR_W-1:0]      st_addr;
  logic                   st_en;
  logic                   busy;
  logic                   done;
  logic                   wrapped;

  output_drain_ctrl #(
    .LANES(LANES), .ACC_W(ACC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .vec_count(vec_count),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .st_data(st_data), .st_addr(st_addr), .st_en(st_en),
    .busy(busy), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } store_t;

  store_t exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every store the DUT issues must match the head of the queue.
  always @(negedge clk) begin
    if (st_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL store_unexpected: got addr=%0d data=%h expected no store at %0t",
                 st_addr, st_data, $time);
      end else begin
        store_t e;
        e = exp_q.pop_front();
        chk("st_addr", 64'(st_addr), 64'(e.addr));
        chk("st_data", 64'(st_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*ACC_W-1:0] pack4(input logic [ACC_W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [LANES*DATA_W-1:0] wpack4(input logic [DATA_W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    start = 1'b1; base_addr = b; vec_count = n;
    tick();
    start = 1'b0;
  endtask

  // Present one vector (already in ACCEPT); queue the first nstore expected stores.
  task automatic send_vec(input logic [LANES*ACC_W-1:0] d, input logic [LANES*DATA_W-1:0] e,
                          input logic [ADDR_W-1:0] a0, input int nstore);
    for (int k = 0; k < nstore; k++) begin
      store_t s;
      s.addr = a0 + ADDR_W'(k);
      s.data = e[k*DATA_W +: DATA_W];
      exp_q.push_back(s);
    end
    res_valid = 1'b1; res_data = d;
    tick();
    res_valid = 1'b0;
  endtask

  // Four cycles after the handshake: done (last vector) or res_ready again.
  task automatic tail(input bit last, input bit inject_start);
    for (int i = 1; i <= LANES; i++) begin
      tick();
      if (inject_start) begin
        start = (i == 1); base_addr = 4'd9; vec_count = 5'd3;
      end
      if (i < LANES) begin
        chk("st_en_during_write", 64'(st_en), 64'(1));
        chk("ready_during_write", 64'(res_ready), 64'(0));
      end
    end
    start = 1'b0;
    chk(last ? "done_at_end" : "no_done_mid", 64'(done), 64'(last));
    chk(last ? "ready_at_end" : "ready_again", 64'(res_ready), 64'(!last));
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready", 64'(res_ready), 64'(0));
    chk("rst_st_en", 64'(st_en), 64'(0));
    chk("rst_st_data", 64'(st_data), 64'(0));
    chk("rst_st_addr", 64'(st_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_wrapped", 64'(wrapped), 64'(0));
    rst = 1'b0;
    tick();

    // Basic job: base 2, one vector
    start_job(4'd2, 5'd1);
    chk("basic_ready", 64'(res_ready), 64'(1));
    chk("basic_busy", 64'(busy), 64'(1));
    send_vec(pack4(40'd10, 40'd20, 40'd30, 40'd40), wpack4(32'd10, 32'd20, 32'd30, 32'd40), 4'd2, 4);
    tail(1'b1, 1'b0);
    chk("basic_wrapped", 64'(wrapped), 64'(0));
    tick();
    chk("basic_done_pulse", 64'(done), 64'(0));
    chk("basic_idle_busy", 64'(busy), 64'(0));

    // Wrap: base 14, two vectors
    start_job(4'd14, 5'd2);
    send_vec(pack4(40'd1, 40'd2, 40'd3, 40'd4), wpack4(32'd1, 32'd2, 32'd3, 32'd4), 4'd14, 4);
    tick();
    chk("wrap_before", 64'(wrapped), 64'(0));
    tick();
    chk("wrap_after15", 64'(wrapped), 64'(1));
    tick(); tick();
    chk("wrap_ready_again", 64'(res_ready), 64'(1));
    send_vec(pack4(40'd5, 40'd6, 40'd7, 40'd8), wpack4(32'd5, 32'd6, 32'd7, 32'd8), 4'd2, 4);
    tail(1'b1, 1'b0);
    chk("wrap_sticky", 64'(wrapped), 64'(1));
    tick();

    // Stall: valid low for 5 cycles, then data changes during WRITE
    start_job(4'd0, 5'd1);
    chk("start_clears_wrapped", 64'(wrapped), 64'(0));
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", 64'(res_ready), 64'(1));
      chk("stall_no_store", 64'(st_en), 64'(0));
      tick();
    end
    send_vec(pack4(40'd100, 40'd101, 40'd102, 40'd103),
             wpack4(32'd100, 32'd101, 32'd102, 32'd103), 4'd0, 4);
    res_data = pack4(40'hAA, 40'hBB, 40'hCC, 40'hDD);
    tail(1'b1, 1'b0);
    tick();

    // Conversion of out-of-range lanes
    start_job(4'd6, 5'd1);
`ifdef OUTPUT_DRAIN_SATURATE_EN
    send_vec(pack4(40'h00_8000_0000, 40'hFF_7FFF_FFFF, 40'hFF_FFFF_FFFF, 40'h00_0000_0005),
             wpack4(32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0005), 4'd6, 4);
`else
    send_vec(pack4(40'h00_8000_0000, 40'hFF_7FFF_FFFF, 40'hFF_FFFF_FFFF, 40'h00_0000_0005),
             wpack4(32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005), 4'd6, 4);
`endif
    tail(1'b1, 1'b0);
    tick();

    // vec_count = 0: done next cycle, no stores, never ready
    start_job(4'd9, 5'd0);
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_ready", 64'(res_ready), 64'(0));
    tick();
    chk("zero_done_once", 64'(done), 64'(0));
    chk("zero_idle", 64'(busy), 64'(0));

    // start pulsed during WRITE is ignored
    start_job(4'd5, 5'd1);
    send_vec(pack4(40'd7, 40'd8, 40'd9, 40'd10), wpack4(32'd7, 32'd8, 32'd9, 32'd10), 4'd5, 4);
    tail(1'b1, 1'b1);
    tick();
    chk("ignored_start_idle", 64'(busy), 64'(0));

    // Reset mid-job after two stores
    start_job(4'd3, 5'd2);
    send_vec(pack4(40'd21, 40'd22, 40'd23, 40'd24), wpack4(32'd21, 32'd22, 32'd23, 32'd24), 4'd3, 2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_st_en", 64'(st_en), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(res_ready), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_done", 64'(done), 64'(0));
    end
    start_job(4'd10, 5'd1);
    chk("restart_ready", 64'(res_ready), 64'(1));
    send_vec(pack4(40'd31, 40'd32, 40'd33, 40'd34), wpack4(32'd31, 32'd32, 32'd33, 32'd34), 4'd10, 4);
    tail(1'b1, 1'b0);
    tick(); tick();

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/output_drain_ctrl.md
# output_drain_ctrl

Collects result vectors from the systolic array's output edge and serializes them, one word per cycle, into the output buffer's single write port (data, store address, store strobe). Sits directly upstream of the output buffer: each accepted vector of LANES accumulator values becomes LANES consecutive buffer writes starting at a host-supplied base address. A drain job covers a programmed number of vectors and ends with a one-cycle done pulse.

## Interface
- LANES, 4, result words per vector from the array
- ACC_W, 40, accumulator width per lane (must be >= DATA_W)
- DATA_W, 32, output buffer word width
- ADDR_W, 4, output buffer address width (16 entries)
- CNT_W, 5, width of vector-count field
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle job start; ignored unless in IDLE
- base_addr  input  ADDR_W  first buffer address of the job, latched on start
- vec_count  input  CNT_W  number of vectors in the job, latched on start
- res_valid  input  1  array presents a vector on res_data
- res_data  input  LANES*ACC_W  lane i at bits [i*ACC_W +: ACC_W]
- res_ready  output  1  block accepts a vector this cycle
- st_data  output  DATA_W  word to output buffer (data)
- st_addr  output  ADDR_W  store address (op_buf_addr_for_store)
- st_en  output  1  store strobe (op_buffer_instr_for_storing_data)
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at job end
- wrapped  output  1  sticky: write pointer wrapped during current job

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: res_ready=0, st_en=0. On start: wr_ptr<=base_addr, remaining<=vec_count, wrapped<=0; go ACCEPT if vec_count!=0, else DONE.
- ACCEPT: res_ready=1. On res_valid: capture all LANES lanes into hold register, lane_idx<=0, go WRITE. Otherwise stay.
- WRITE: res_ready=0; each cycle st_en=1, st_addr=wr_ptr, st_data=convert(hold[lane_idx]); wr_ptr<=wr_ptr+1 modulo 2^ADDR_W; if wr_ptr was all-ones, wrapped<=1. On lane_idx==LANES-1: remaining<=remaining-1; go DONE if remaining==1, else ACCEPT. Otherwise lane_idx<=lane_idx+1.
- DONE: done=1 for exactly this cycle; next state IDLE.
- convert(): default truncation to the low DATA_W bits of the lane (see Configuration).
- Address wrap is legal: writes beyond entry 2^ADDR_W-1 continue at 0 and overwrite; wrapped flags it. wrapped holds until the next accepted start or rst.
- start outside IDLE is ignored; in-flight job is unaffected.
- res_data is sampled only on the ACCEPT handshake cycle; later changes do not affect the in-progress vector.

## Timing
- Reset values: state IDLE, res_ready=0, st_en=0, st_data=0, st_addr=0, busy=0, done=0, wrapped=0; wr_ptr, remaining, lane_idx cleared.
- rst mid-job: next cycle is IDLE with all reset values; writes already issued stay in the buffer; no done pulse.
- st_data/st_addr/st_en are registered outputs, valid in the same cycle as st_en=1.
- start at cycle t -> res_ready=1 at t+1.
- Handshake at cycle h -> stores at h+1 .. h+LANES -> res_ready=1 again at h+LANES+1 (or done at h+LANES+1 on the last vector).
- Peak throughput: one vector per LANES+1 cycles; no back-pressure from the buffer (store accepted every cycle).
- vec_count=0: start at t -> done at t+1, no stores, res_ready never asserted.
- Job of N vectors with no array stall: done at t+1+N*(LANES+1).

## Configuration
- OUTPUT_DRAIN_SATURATE_EN defined: convert() is signed saturation of the ACC_W lane to DATA_W: values > 2^(DATA_W-1)-1 give 0x7FFFFFFF, values < -2^(DATA_W-1) give 0x80000000, otherwise the low DATA_W bits.
- Not defined: convert() is plain truncation to the low DATA_W bits; no comparison logic is built.

## Test plan
- Basic job: base_addr=2, vec_count=1, lanes {10,20,30,40} -> st_en on 4 consecutive cycles, addr 2,3,4,5, data 10,20,30,40; done 1 cycle later; wrapped=0.
- Wrap: base_addr=14, vec_count=2, lanes {1,2,3,4} then {5,6,7,8} -> addr 14,15,0,1,2,3,4,5, data 1..8 in order; wrapped=1 after the write to 15.
- Stall/back-pressure: res_valid held low 5 cycles in ACCEPT -> res_ready stays 1, st_en stays 0; vector taken on first valid cycle; res_data changed during WRITE does not alter st_data.
- Saturation (macro defined): lane 0x00_8000_0000 -> 0x7FFFFFFF; lane 0xFF_7FFF_FFFF -> 0x80000000; lane 0xFF_FFFF_FFFF -> 0xFFFFFFFF. Macro undefined: same inputs -> 0x80000000, 0x7FFFFFFF, 0xFFFFFFFF.
- Corner starts: vec_count=0 -> done at t+1, no stores; start pulsed during WRITE -> ignored, job completes with original base/count.
- Reset mid-job: rst during WRITE after 2 stores -> next cycle st_en=0, busy=0, res_ready=0, no done pulse; new start then runs normally from new base_addr.
